// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer and the control unit:
// the fetch state encoding and the instruction set opcodes.
package instr_fetch_ctrl_pkg;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_PRESENT = 3'd4,
    ST_HALT    = 3'd5
  } fetch_state_e;

  // Instruction set opcodes (one 8-bit word per instruction)
  localparam int OP_LOADA = 1;
  localparam int OP_LOADB = 2;
  localparam int OP_STORE = 3;
  localparam int OP_ADD   = 4;
  localparam int OP_SUB   = 5;
  localparam int OP_AND   = 6;
  localparam int OP_OR    = 7;
  localparam int OP_XOR   = 8;
  localparam int OP_JMP   = 16;
  localparam int OP_JZ    = 17;
  localparam int OP_OUT   = 24;
  localparam int OP_ENDOP = 25;
  localparam int OP_NOP   = 26;

  // True when an instruction word is the end-of-program opcode
  function automatic logic is_endop(input logic [7:0] instr);
    return instr == 8'(OP_ENDOP);
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction memory reads, absorbs
// the one-cycle read latency and presents each fetched word to the control
// unit over a valid/ready handshake. Also gates host program loading,
// accepts jump redirects and stops on the end-of-program opcode.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int START_ADDR  = 0,
  parameter int HALT_OPCODE = OP_ENDOP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_en,
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  start,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [DATA_WIDTH-1:0] mem_w_instr,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  input  logic [DATA_WIDTH-1:0] mem_r_instr,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  busy,
  output logic                  halted
);

  localparam logic [ADDR_WIDTH-1:0] START_PC = ADDR_WIDTH'(START_ADDR);
  localparam logic [DATA_WIDTH-1:0] HALT_OP  = DATA_WIDTH'(HALT_OPCODE);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;

  // The read address is the PC register itself, so it never glitches
  assign mem_r_addr = pc;

  // Host write port: a straight pass-through, enabled only while loading
  assign mem_we      = (state == ST_LOAD) && load_valid;
  assign mem_w_addr  = load_addr;
  assign mem_w_instr = load_data;

  // Status flags decode the registered state, so ir_ready/redirect never reach them
  assign ir_valid = (state == ST_PRESENT);
  assign busy     = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_PRESENT);
  assign halted   = (state == ST_HALT);

  // Fetch FSM: load gating, issue/wait/present cycle, redirects and halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pc      <= START_PC;
      ir_data <= '0;
      ir_pc   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (load_en) begin
            state <= ST_LOAD;
          end else if (start) begin
            state <= ST_ISSUE;
            pc    <= START_PC;
          end
        end

        ST_LOAD: begin
          if (!load_en) begin
            state <= ST_IDLE;
          end
        end

        ST_ISSUE, ST_WAIT, ST_PRESENT: begin
          if (load_en) begin
            state <= ST_LOAD;
          end else if (redirect_valid) begin
            // Any word in flight is dropped; the jump target is fetched next
            state <= ST_ISSUE;
            pc    <= redirect_addr;
          end else if (state == ST_ISSUE) begin
            state <= ST_WAIT;
          end else if (state == ST_WAIT) begin
            ir_data <= mem_r_instr;
            ir_pc   <= pc;
            pc      <= pc + ADDR_WIDTH'(1);
            state   <= ST_PRESENT;
          end else if (ir_ready) begin
            state <= (ir_data == HALT_OP) ? ST_HALT : ST_ISSUE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: an instruction memory with a
// one-cycle registered read, a behavioural model of the fetch sequencer,
// a per-cycle compare process and directed scenarios with literal checks.
module tb_instr_fetch_ctrl;

  localparam int MODE_IDLE = 0;
  localparam int MODE_LOAD = 1;
  localparam int MODE_RUN  = 2;
  localparam int MODE_HALT = 3;
  localparam logic [7:0] ENDOP = 8'd25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_en, load_valid, start, ir_ready, redirect_valid;
  logic [7:0] load_addr, load_data, redirect_addr;
  logic       mem_we, ir_valid, busy, halted;
  logic [7:0] mem_w_addr, mem_w_instr, mem_r_addr, ir_data, ir_pc;
  logic [7:0] mem_r_instr = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] env_mem [256] = '{default: 8'h00};

  // Model state: run mode, fetch age (1 issue, 2 waiting, 3 presenting)
  int         m_mode;
  int         m_age;
  logic [7:0] m_addr;
  logic [7:0] m_ir_data;
  logic [7:0] m_ir_pc;
  logic [7:0] m_mem [256] = '{default: 8'h00};

  instr_fetch_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (8),
    .START_ADDR (0),
    .HALT_OPCODE(25)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_en       (load_en),
    .load_valid    (load_valid),
    .load_addr     (load_addr),
    .load_data     (load_data),
    .start         (start),
    .mem_we        (mem_we),
    .mem_w_addr    (mem_w_addr),
    .mem_w_instr   (mem_w_instr),
    .mem_r_addr    (mem_r_addr),
    .mem_r_instr   (mem_r_instr),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .busy          (busy),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous write, registered read
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_w_addr] <= mem_w_instr;
    mem_r_instr <= env_mem[mem_r_addr];
  end

  // Behavioural model of the sequencer, stepped on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode    <= MODE_IDLE;
      m_age     <= 0;
      m_addr    <= 8'h00;
      m_ir_data <= 8'h00;
      m_ir_pc   <= 8'h00;
    end else if (m_mode == MODE_IDLE || m_mode == MODE_HALT) begin
      if (load_en) m_mode <= MODE_LOAD;
      else if (start) begin
        m_mode <= MODE_RUN;
        m_age  <= 1;
        m_addr <= 8'h00;
      end
    end else if (m_mode == MODE_LOAD) begin
      if (load_valid) m_mem[load_addr] <= load_data;
      if (!load_en) m_mode <= MODE_IDLE;
    end else begin
      if (load_en) m_mode <= MODE_LOAD;
      else if (redirect_valid) begin
        m_addr <= redirect_addr;
        m_age  <= 1;
      end else if (m_age < 2) m_age <= 2;
      else if (m_age == 2) begin
        m_ir_data <= m_mem[m_addr];
        m_ir_pc   <= m_addr;
        m_addr    <= m_addr + 8'd1;
        m_age     <= 3;
      end else if (ir_ready) begin
        if (m_ir_data == ENDOP) m_mode <= MODE_HALT;
        else m_age <= 1;
      end
    end
  end

  // One comparison: count it and report a mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic compareModel();
    logic exp_we;
    exp_we = (m_mode == MODE_LOAD) && load_valid;
    checkOutput("ir_valid", 32'(ir_valid), 32'((m_mode == MODE_RUN) && (m_age == 3)));
    checkOutput("busy", 32'(busy), 32'(m_mode == MODE_RUN));
    checkOutput("halted", 32'(halted), 32'(m_mode == MODE_HALT));
    checkOutput("mem_r_addr", 32'(mem_r_addr), 32'(m_addr));
    checkOutput("ir_data", 32'(ir_data), 32'(m_ir_data));
    checkOutput("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
    checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      checkOutput("mem_w_addr", 32'(mem_w_addr), 32'(load_addr));
      checkOutput("mem_w_instr", 32'(mem_w_instr), 32'(load_data));
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after each rising edge
  task automatic compareLoop();
    forever begin
      @(posedge clk);
      #1;
      compareModel();
    end
  endtask

  // Drive every input of the block at once
  task automatic applyStimulus(input logic le, input logic lv, input logic [7:0] la,
                               input logic [7:0] ld, input logic st, input logic rdy);
    load_en    = le;
    load_valid = lv;
    load_addr  = la;
    load_data  = ld;
    start      = st;
    ir_ready   = rdy;
  endtask

  // Advance to the next falling edge; start and redirect are one-cycle pulses
  task automatic tick();
    @(negedge clk);
    start          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  // Wait (bounded) for the next presented word and check it and its latency
  task automatic waitPresent(input logic [7:0] exp_data, input logic [7:0] exp_pc, input int exp_cycles);
    int n;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ir_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL present_timeout: no ir_valid within 12 cycles, expected word %0h at pc %0h", exp_data, exp_pc);
    end else begin
      checkOutput("present_latency", 32'(n), 32'(exp_cycles));
      checkOutput("present_data", 32'(ir_data), 32'(exp_data));
      checkOutput("present_pc", 32'(ir_pc), 32'(exp_pc));
    end
  endtask

  // Program image: address/word pairs written by the host
  logic [7:0] prog_addr [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h10, 8'h11, 8'hFF, 8'h07};
  logic [7:0] prog_data [11] = '{8'd26, 8'd26, 8'd25, 8'd26, 8'd25, 8'd28, 8'd25, 8'd29, 8'd25, 8'd26, 8'd26};

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'h00;
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    fork
      compareLoop();
    join_none

    // Reset values
    tick();
    tick();
    checkOutput("rst_mem_r_addr", 32'(mem_r_addr), 32'h0);
    checkOutput("rst_ir_valid", 32'(ir_valid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_ir_data", 32'(ir_data), 32'h0);
    rst_n = 1'b1;
    tick();

    // Host program load
    $display("[TB] loading program");
    applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, 1'b1, prog_addr[i], prog_data[i], 1'b0, 1'b1);
      #1;
      checkOutput("load_mem_we", 32'(mem_we), 32'h1);
      checkOutput("load_w_addr", 32'(mem_w_addr), 32'(prog_addr[i]));
      tick();
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();

    // Run 26, 26, 25 from address 0 with ir_ready held high
    $display("[TB] straight-line run to ENDOP");
    start = 1'b1;
    waitPresent(8'd26, 8'h00, 3);
    waitPresent(8'd26, 8'h01, 3);
    waitPresent(8'd25, 8'h02, 3);
    tick();
    checkOutput("halt_halted", 32'(halted), 32'h1);
    checkOutput("halt_busy", 32'(busy), 32'h0);

    // Back-pressure: ir_ready low for 5 cycles, start pulse ignored
    $display("[TB] stall in PRESENT");
    ir_ready = 1'b0;
    start    = 1'b1;
    waitPresent(8'd26, 8'h00, 3);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      checkOutput("stall_valid", 32'(ir_valid), 32'h1);
      checkOutput("stall_data", 32'(ir_data), 32'd26);
      checkOutput("stall_pc", 32'(ir_pc), 32'h00);
      checkOutput("stall_r_addr", 32'(mem_r_addr), 32'h01);
    end
    ir_ready = 1'b1;
    waitPresent(8'd26, 8'h01, 3);

    // Redirect during WAIT: fetch of address 2 is discarded
    $display("[TB] redirect during WAIT");
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 8'h10;
    tick();
    checkOutput("redir_r_addr", 32'(mem_r_addr), 32'h10);
    checkOutput("redir_valid", 32'(ir_valid), 32'h0);
    waitPresent(8'd29, 8'h10, 2);
    waitPresent(8'd25, 8'h11, 3);

    // Redirect together with the ENDOP handshake: redirect wins
    $display("[TB] redirect on ENDOP handshake");
    redirect_valid = 1'b1;
    redirect_addr  = 8'h05;
    tick();
    checkOutput("redir_halt_halted", 32'(halted), 32'h0);
    checkOutput("redir_halt_busy", 32'(busy), 32'h1);
    waitPresent(8'd28, 8'h05, 2);
    waitPresent(8'd25, 8'h06, 3);
    tick();
    checkOutput("halt2_halted", 32'(halted), 32'h1);

    // PC wrap from 0xFF to 0x00
    $display("[TB] pc wrap");
    start = 1'b1;
    waitPresent(8'd26, 8'h00, 3);
    redirect_valid = 1'b1;
    redirect_addr  = 8'hFF;
    waitPresent(8'd26, 8'hFF, 3);
    checkOutput("wrap_r_addr", 32'(mem_r_addr), 32'h00);
    waitPresent(8'd26, 8'h00, 3);
    waitPresent(8'd26, 8'h01, 3);
    waitPresent(8'd25, 8'h02, 3);
    tick();
    checkOutput("halt3_halted", 32'(halted), 32'h1);

    // load_en aborts execution and beats a redirect; redirects ignored when idle
    $display("[TB] load abort and ignored redirects");
    ir_ready = 1'b0;
    start    = 1'b1;
    waitPresent(8'd26, 8'h00, 3);
    load_en        = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 8'h40;
    tick();
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_valid", 32'(ir_valid), 32'h0);
    checkOutput("abort_r_addr", 32'(mem_r_addr), 32'h01);
    redirect_valid = 1'b1;
    tick();
    load_en = 1'b0;
    tick();
    redirect_valid = 1'b1;
    tick();
    checkOutput("idle_redir_r_addr", 32'(mem_r_addr), 32'h01);

    // Reset asserted while presenting
    $display("[TB] reset during PRESENT");
    start = 1'b1;
    waitPresent(8'd26, 8'h00, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstp_valid", 32'(ir_valid), 32'h0);
    checkOutput("rstp_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rstp_r_addr", 32'(mem_r_addr), 32'h00);
    checkOutput("rstp_busy", 32'(busy), 32'h0);
    checkOutput("rstp_ir_pc", 32'(ir_pc), 32'h00);
    checkOutput("rstp_ir_data", 32'(ir_data), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset asserted mid-write while loading
    $display("[TB] reset during LOAD");
    load_en = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 8'h30, 8'h55, 1'b0, 1'b0);
    #1;
    checkOutput("rstl_we_before", 32'(mem_we), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstl_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rstl_busy", 32'(busy), 32'h0);
    checkOutput("rstl_halted", 32'(halted), 32'h0);
    checkOutput("rstl_r_addr", 32'(mem_r_addr), 32'h00);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
